// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, PSR bit indices, default widths,
// buffer occupancy encoding and the opcode classifiers used by the decoder
// and by the writeback stage.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned FLAG_W_DEF = 5;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // PSR bit map
  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_N = 4;

  // Full-byte opcodes
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_CMPU = 8'h0C;

  // Immediate-form groups, identified by the high nibble
  localparam logic [3:0] GRP_ADDI  = 4'h5;
  localparam logic [3:0] GRP_ADDCI = 4'h7;
  localparam logic [3:0] GRP_SUBI  = 4'h9;
  localparam logic [3:0] GRP_CMPI  = 4'hB;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Opcodes whose flags are committed to the PSR
  function automatic logic is_flag_op(input logic [7:0] opcode);
    logic [3:0] grp;
    grp = opcode[7:4];
    return (opcode == OP_ADD) || (opcode == OP_ADDC) || (opcode == OP_SUB) ||
           (opcode == OP_CMP) || (opcode == OP_CMPU) ||
           (grp == GRP_ADDI) || (grp == GRP_ADDCI) || (grp == GRP_SUBI) ||
           (grp == GRP_CMPI);
  endfunction

  // Opcodes that produce a register-file write (compares and NOP do not)
  function automatic logic is_wb_op(input logic [7:0] opcode);
    return !((opcode == OP_NOP) || (opcode == OP_CMP) || (opcode == OP_CMPU) ||
             (opcode[7:4] == GRP_CMPI));
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer with registered in_ready and out_valid.
// Ports: clk, reset_n (async active-low), flush (sync discard),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//        (downstream; out_data is the head entry).
module skid_buffer
  import alu_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_t   state, state_nxt;
  logic [W-1:0] main_q, main_nxt;
  logic [W-1:0] skid_q, skid_nxt;
  logic         in_ready_nxt, out_valid_nxt;
  logic         accept, push;

  assign accept   = in_valid && in_ready;
  assign push     = out_valid && out_ready;
  assign out_data = main_q;

  // State, storage and handshake registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OCC_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Occupancy transitions; main always holds the head entry
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      OCC_EMPTY: begin
        if (accept) begin
          state_nxt = OCC_ONE;
          main_nxt  = in_data;
        end
      end
      OCC_ONE: begin
        if (accept && !push) begin
          state_nxt = OCC_TWO;
          skid_nxt  = in_data;
        end else if (accept && push) begin
          main_nxt = in_data;
        end else if (push) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (push) begin
          state_nxt = OCC_ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end
    in_ready_nxt  = (state_nxt != OCC_TWO);
    out_valid_nxt = (state_nxt != OCC_EMPTY);
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the combinational ALU: buffers results for the
// register-file write port, owns the PSR and counts retired writebacks.
// Ports: clk, reset_n (async active-low), flush; ALU side in_valid/in_ready,
//        alu_c, alu_flags, alu_opcode, dest_addr; writeback side wb_valid,
//        wb_ready, wb_data, wb_addr; psr, psr_carry (ALU carry-in), retire_cnt.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FLAG_W = FLAG_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [7:0]        alu_opcode,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [FLAG_W-1:0] psr,
  output logic              psr_carry,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

  logic               accept, push, buf_in_valid;
  logic [ENTRY_W-1:0] wb_entry;

  assign accept = in_valid && in_ready;
  assign push   = wb_valid && wb_ready;

  // Compares/NOP are accepted but never occupy a buffer slot
  assign buf_in_valid = in_valid && !flush && is_wb_op(alu_opcode);

  skid_buffer #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (buf_in_valid),
    .in_ready  (in_ready),
    .in_data   ({dest_addr, alu_c}),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_data  (wb_entry)
  );

  assign wb_data   = wb_entry[DATA_W-1:0];
  assign wb_addr   = wb_entry[DATA_W +: ADDR_W];
  assign psr_carry = psr[PSR_C];

  // PSR commits on the accept edge; a flushed accept is discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr <= '0;
    end else if (accept && !flush && is_flag_op(alu_opcode)) begin
      psr <= alu_flags;
    end
  end

  // Retired writebacks, wrapping; a push coincident with flush still counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (push) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;

  localparam logic [7:0] T_NOP  = 8'h00;
  localparam logic [7:0] T_ADD  = 8'h01;
  localparam logic [7:0] T_AND  = 8'h02;
  localparam logic [7:0] T_ADDC = 8'h07;
  localparam logic [7:0] T_SUB  = 8'h09;
  localparam logic [7:0] T_CMP  = 8'h0B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_c = '0;
  logic [4:0]  alu_flags = '0;
  logic [7:0]  alu_opcode = '0;
  logic [3:0]  dest_addr = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic [4:0]  psr;
  logic        psr_carry;
  logic [15:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of pending {addr,data}, PSR and retire count
  logic [19:0] mq[$];
  logic [4:0]  m_psr = '0;
  logic [15:0] m_cnt = '0;

  alu_writeback_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .alu_c(alu_c), .alu_flags(alu_flags),
    .alu_opcode(alu_opcode), .dest_addr(dest_addr), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr), .psr(psr),
    .psr_carry(psr_carry), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit ref_flag(input logic [7:0] op);
    logic [3:0] hi;
    hi = op[7:4];
    return (op inside {8'h01, 8'h07, 8'h09, 8'h0B, 8'h0C}) ||
           (hi inside {4'h5, 4'h7, 4'h9, 4'hB});
  endfunction

  function automatic bit ref_wb(input logic [7:0] op);
    logic [3:0] hi;
    hi = op[7:4];
    return !((op inside {8'h00, 8'h0B, 8'h0C}) || (hi == 4'hB));
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at next negedge
  task automatic cycle(input bit v, input logic [7:0] op, input logic [15:0] c,
                       input logic [4:0] f, input logic [3:0] a, input bit rdy,
                       input bit fl, output bit acc);
    bit pushed;
    in_valid = v; alu_opcode = op; alu_c = c; alu_flags = f; dest_addr = a;
    wb_ready = rdy; flush = fl;
    acc    = v && (mq.size() < 2);
    pushed = (mq.size() > 0) && rdy;
    @(posedge clk);
    if (pushed) m_cnt = m_cnt + 16'd1;
    if (fl) mq.delete();
    else begin
      if (pushed) void'(mq.pop_front());
      if (acc && ref_wb(op)) mq.push_back({a, c});
      if (acc && ref_flag(op)) m_psr = f;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if ({wb_data, wb_addr} !== 20'h0) begin errors++; $display("FAIL reset_wb_payload got %h exp 0", {wb_data, wb_addr}); end
    checks++; if (psr !== 5'h0 || retire_cnt !== 16'h0) begin errors++; $display("FAIL reset_psr_cnt got %h/%h exp 0/0", psr, retire_cnt); end
    // Mid-burst asynchronous reset with two entries buffered and a nonzero PSR
    cycle(1'b1, T_ADD, 16'hAAAA, 5'h1F, 4'h3, 1'b0, 1'b0, acc);
    cycle(1'b1, T_AND, 16'h5555, 5'h00, 4'h4, 1'b0, 1'b0, acc);
    in_valid = 1'b1; alu_opcode = T_ADD;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b exp 1", in_ready); end
    checks++; if (wb_valid !== 1'b0 || wb_data !== 16'h0 || wb_addr !== 4'h0) begin errors++; $display("FAIL async_reset_wb got %b/%h/%h exp 0/0/0", wb_valid, wb_data, wb_addr); end
    checks++; if (psr !== 5'h0 || psr_carry !== 1'b0 || retire_cnt !== 16'h0) begin errors++; $display("FAIL async_reset_psr got %h/%b/%h exp 0", psr, psr_carry, retire_cnt); end
    in_valid = 1'b0;
    mq.delete(); m_psr = '0; m_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
      checks++; if (wb_valid !== 1'b0 || retire_cnt !== 16'h0) begin errors++; $display("FAIL post_reset_idle got %b/%h exp 0/0", wb_valid, retire_cnt); end
    end
  endtask

  task automatic test_streaming();
    bit acc;
    logic [15:0] c0;
    c0 = retire_cnt;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, T_ADD, 16'(i), 5'h0, 4'(i), 1'b1, 1'b0, acc);
      checks++; if (wb_valid !== 1'b1 || wb_data !== 16'(i) || wb_addr !== 4'(i)) begin errors++; $display("FAIL stream_%0d got %b/%h/%h exp 1/%h/%h", i, wb_valid, wb_data, wb_addr, i, i); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %b exp 1", i, in_ready); end
    end
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
    checks++; if (retire_cnt !== c0 + 16'd4 || wb_valid !== 1'b0) begin errors++; $display("FAIL stream_count got %h/%b exp %h/0", retire_cnt, wb_valid, c0 + 16'd4); end
  endtask

  task automatic test_back_to_back();
    bit acc, done;
    logic [15:0] got[$];
    logic [15:0] c0;
    c0 = m_cnt;
    cycle(1'b1, T_AND, 16'd10, 5'h0, 4'h5, 1'b0, 1'b0, acc);
    cycle(1'b1, T_AND, 16'd20, 5'h0, 4'h6, 1'b0, 1'b0, acc);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    // Third op held while full: must not be taken
    cycle(1'b1, T_AND, 16'd30, 5'h0, 4'h7, 1'b0, 1'b0, acc);
    checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 16'd10 || wb_addr !== 4'h5) begin errors++; $display("FAIL bp_hold got %b/%b/%h/%h exp 0/1/000a/5", in_ready, wb_valid, wb_data, wb_addr); end
    done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (wb_valid) got.push_back(wb_data);
      if (!done) begin
        cycle(1'b1, T_AND, 16'd30, 5'h0, 4'h7, 1'b1, 1'b0, acc);
        if (acc) done = 1'b1;
      end else begin
        cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
      end
      if (done && !wb_valid) break;
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_pop_count got %0d exp 3", got.size()); end
    else begin
      checks++; if (got[0] !== 16'd10 || got[1] !== 16'd20 || got[2] !== 16'd30) begin errors++; $display("FAIL bp_order got %0d,%0d,%0d exp 10,20,30", got[0], got[1], got[2]); end
    end
    checks++; if (retire_cnt !== c0 + 16'd3) begin errors++; $display("FAIL bp_count got %h exp %h", retire_cnt, c0 + 16'd3); end
  endtask

  task automatic test_psr_rules();
    bit acc;
    logic [15:0] c0;
    cycle(1'b1, T_ADD, 16'h1234, 5'b01000, 4'h1, 1'b1, 1'b0, acc);
    checks++; if (psr !== 5'h08) begin errors++; $display("FAIL psr_add got %h exp 08", psr); end
    cycle(1'b1, T_AND, 16'h0F0F, 5'b10111, 4'h2, 1'b1, 1'b0, acc);
    checks++; if (psr !== 5'h08) begin errors++; $display("FAIL psr_and got %h exp 08", psr); end
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
    c0 = retire_cnt;
    cycle(1'b1, T_CMP, 16'hBEEF, 5'b00010, 4'h9, 1'b1, 1'b0, acc);
    checks++; if (psr !== 5'h02 || wb_valid !== 1'b0) begin errors++; $display("FAIL psr_cmp got %h/%b exp 02/0", psr, wb_valid); end
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
    checks++; if (retire_cnt !== c0 || wb_valid !== 1'b0) begin errors++; $display("FAIL cmp_no_wb got %h/%b exp %h/0", retire_cnt, wb_valid, c0); end
  endtask

  task automatic test_carry_loop();
    bit acc;
    cycle(1'b1, T_ADD, 16'hFFFF, 5'b00001, 4'h1, 1'b1, 1'b0, acc);
    // ADDC is being presented right now, one cycle after the ADD accept
    checks++; if (psr_carry !== 1'b1) begin errors++; $display("FAIL carry_in got %b exp 1", psr_carry); end
    cycle(1'b1, T_ADDC, 16'h0001, 5'b00000, 4'h2, 1'b1, 1'b0, acc);
    checks++; if (psr_carry !== 1'b0 || psr !== 5'h00) begin errors++; $display("FAIL carry_clear got %b/%h exp 0/00", psr_carry, psr); end
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic test_flush();
    bit acc;
    logic [4:0]  p0;
    logic [15:0] c0;
    cycle(1'b1, T_ADD, 16'h0, 5'b10101, 4'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
    p0 = 5'b10101;
    cycle(1'b1, T_AND, 16'h0111, 5'h0, 4'h1, 1'b0, 1'b0, acc);
    cycle(1'b1, T_AND, 16'h0222, 5'h0, 4'h2, 1'b0, 1'b0, acc);
    c0 = retire_cnt;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %b exp 0", in_ready); end
    cycle(1'b1, T_SUB, 16'h0333, 5'b01010, 4'h3, 1'b0, 1'b1, acc);
    checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_two got %b/%b exp 1/0", in_ready, wb_valid); end
    checks++; if (psr !== p0 || retire_cnt !== c0) begin errors++; $display("FAIL flush_two_keep got %h/%h exp %h/%h", psr, retire_cnt, p0, c0); end
    // Flush in ONE with coincident accept and push
    cycle(1'b1, T_AND, 16'h0444, 5'h0, 4'h4, 1'b0, 1'b0, acc);
    cycle(1'b1, T_SUB, 16'h0555, 5'b01010, 4'h5, 1'b1, 1'b1, acc);
    checks++; if (psr !== p0 || retire_cnt !== c0 + 16'd1 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_one got %h/%h/%b exp %h/%h/0", psr, retire_cnt, wb_valid, p0, c0 + 16'd1); end
    cycle(1'b0, T_NOP, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0, acc);
    checks++; if (wb_valid !== 1'b0 || retire_cnt !== c0 + 16'd1) begin errors++; $display("FAIL flush_discard got %b/%h exp 0/%h", wb_valid, retire_cnt, c0 + 16'd1); end
  endtask

  task automatic test_random();
    bit acc, v, rdy, fl;
    logic [7:0] op;
    logic [7:0] picks[8];
    picks = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h0B, 8'h0C, 8'h5A, 8'hB3};
    for (int k = 0; k < 400; k++) begin
      checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_in_ready@%0d got %b exp %b", k, in_ready, mq.size() < 2); end
      checks++; if (wb_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_wb_valid@%0d got %b exp %b", k, wb_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        checks++; if ({wb_addr, wb_data} !== mq[0]) begin errors++; $display("FAIL rnd_payload@%0d got %h exp %h", k, {wb_addr, wb_data}, mq[0]); end
      end
      checks++; if (psr !== m_psr || psr_carry !== m_psr[0]) begin errors++; $display("FAIL rnd_psr@%0d got %h exp %h", k, psr, m_psr); end
      checks++; if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt@%0d got %h exp %h", k, retire_cnt, m_cnt); end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 19) == 0);
      op  = ($urandom_range(0, 1) != 0) ? picks[$urandom_range(0, 7)] : 8'($urandom);
      cycle(v, op, 16'($urandom), 5'($urandom), 4'($urandom), rdy, fl, acc);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_psr_rules();
    test_carry_loop();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
